// File: rtl/strobe_trace_logger.sv
`timescale 1ns/1ps
// strobe_trace_logger: cycle-stamped multi-channel sample logger feeding a valid/ready trace stream.
// Records are dropped (and counted) on overflow; FSTROBE_TRACE_LOG_EN adds a sim-only text log.
//   state   | meaning
//   S_EMPTY | nothing presented, rec_valid low
//   S_HOLD  | rec_data holds the FIFO head, rec_valid high
module strobe_trace_logger #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
`ifdef FSTROBE_TRACE_LOG_EN
  ,
  parameter string LOG_FILE = "trace.txt"
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic [NUM_CH-1:0]                     ch_en,
  input  logic [NUM_CH*DATA_W-1:0]              ch_data,
  output logic                                  rec_valid,
  input  logic                                  rec_ready,
  output logic [TS_W+NUM_CH+NUM_CH*DATA_W-1:0]  rec_data,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  full,
  output logic                                  overflow,
  output logic [DROP_W-1:0]                     drop_cnt
);
  localparam int REC_W = TS_W + NUM_CH + NUM_CH*DATA_W;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                   state;
  logic [TS_W-1:0]          ts;
  logic [AW:0]              wptr, rptr, wptr_nxt, rptr_nxt;
  logic [REC_W-1:0]         mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] data_m;
  logic [REC_W-1:0]         new_rec, head_nxt;
  logic                     push_req, pop, push_ok, drop;

  always_comb begin
    data_m = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_en[i]) data_m[i*DATA_W +: DATA_W] = ch_data[i*DATA_W +: DATA_W];
  end

  assign new_rec  = {ts, ch_en, data_m};
  assign count    = wptr - rptr;
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_req = |ch_en;
  assign pop      = rec_valid && rec_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wptr_nxt = wptr + {{AW{1'b0}}, push_ok};
  assign rptr_nxt = rptr + {{AW{1'b0}}, pop};
  // The incoming record becomes the head when it lands in the slot the read pointer moves to.
  assign head_nxt = (push_ok && (rptr_nxt == wptr)) ? new_rec : mem[rptr_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wptr[AW-1:0]] <= new_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      rec_valid <= 1'b0;
      rec_data  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr) begin
      state     <= S_EMPTY;
      rec_valid <= 1'b0;
      rec_data  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      rec_data <= (wptr_nxt == rptr_nxt) ? '0 : head_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
      end
      case (state)
        S_EMPTY: if (push_ok) begin
          state     <= S_HOLD;
          rec_valid <= 1'b1;
        end
        S_HOLD: if (pop && (count == (AW+1)'(1)) && !push_ok) begin
          state     <= S_EMPTY;
          rec_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FSTROBE_TRACE_LOG_EN
  int unsigned log_drops = 0;

  always @(posedge clk) begin
    if (rst_n && !clr) begin
      if (push_ok) begin
        $display("%0d %b %h", ts, ch_en, data_m);
      end else if (drop) begin
        log_drops = log_drops + 1;
        $display("DROP %0d", log_drops);
      end
    end
  end
`endif
endmodule
